// File: rtl/ft2232h_pkg.sv
// Shared constants and types for the FT2232H round-robin TX arbiter.
package ft2232h_pkg;

   localparam int         FT_BYTE_W = 8;
   localparam logic [3:0] HDR_MAGIC = 4'hA;

   typedef enum logic {
      IDLE,
      PAYLOAD
   } state_t;

   // Index width that stays at least 1 bit wide when a single requester is configured.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ft2232h_tx_arbiter_if.sv
// Requester byte streams plus the FT2232H synchronous-FIFO write pins as one bundle.
interface ft2232h_tx_arbiter_if #(
   parameter int NCH = 4
);
   logic [NCH-1:0]                          req_valid_i;
   logic [NCH*ft2232h_pkg::FT_BYTE_W-1:0]   req_data_i;
   logic [NCH-1:0]                          req_ready_o;
   logic                                    txe_n_i;
   logic                                    wr_n_o;
   logic [ft2232h_pkg::FT_BYTE_W-1:0]       data_o;
   logic                                    siwu_n_o;
   logic                                    busy_o;

   modport master (
      input  req_valid_i, req_data_i, txe_n_i,
      output req_ready_o, wr_n_o, data_o, siwu_n_o, busy_o
   );

   modport slave (
      output req_valid_i, req_data_i, txe_n_i,
      input  req_ready_o, wr_n_o, data_o, siwu_n_o, busy_o
   );
endinterface

// File: rtl/ft2232h_tx_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NCH = 4,
   parameter int GW  = 2
) (
   input  logic [NCH-1:0] req,
   input  logic [GW-1:0]  ptr,
   output logic [NCH-1:0] grant_oh,
   output logic [GW-1:0]  grant_bin
);

   always_comb begin
      logic          found;
      logic [GW-1:0] idx;
      // NOTE: every output gets a default before the search so no path leaves a latch.
      grant_oh  = '0;
      grant_bin = '0;
      found     = 1'b0;
      idx       = '0;
      for (int i = 0; i < NCH; i++) begin
         idx = GW'((int'(ptr) + i) % NCH);
         if (!found && req[idx]) begin
            found         = 1'b1;
            grant_oh[idx] = 1'b1;
            grant_bin     = idx;
         end
      end
   end

endmodule

// File: rtl/ft2232h_tx_arbiter.sv
// Round-robin packet scheduler onto the FT2232H sync-FIFO write port (header + BURST_LEN bytes).
// Optional FT_SIWU_EN: pulse SIWU# once the link goes quiet after a packet to flush the host buffer.
module ft2232h_tx_arbiter
   import ft2232h_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int BURST_LEN = 16,
   parameter int CH_W      = 4
) (
   input  logic                 clkout_i,
   input  logic                 rst_n_i,
   ft2232h_tx_arbiter_if.master bus
);

   localparam int GW = idx_w(NCH);
   localparam int CW = $clog2(BURST_LEN + 1);

   state_t                 state;
   logic                   out_valid;
   logic [FT_BYTE_W-1:0]   data_q;
   logic [GW-1:0]          rr_ptr;
   logic [GW-1:0]          grant_q;
   logic [CW-1:0]          byte_cnt;

   logic [NCH-1:0]         grant_oh;
   logic [GW-1:0]          grant_bin;
   logic [NCH-1:0]         req_ready;
   logic [FT_BYTE_W-1:0]   req_byte [NCH];
   logic [GW-1:0]          next_ptr;
   logic [CH_W-1:0]        hdr_ch;
   logic                   any_req, xfer, slot_free, start, accept, last_accept;

   for (genvar k = 0; k < NCH; k++) begin : g_unpack
      assign req_byte[k] = bus.req_data_i[k*FT_BYTE_W +: FT_BYTE_W];
   end

   rr_arbiter #(
      .NCH (NCH),
      .GW  (GW)
   ) u_rr (
      .req       (bus.req_valid_i),
      .ptr       (rr_ptr),
      .grant_oh  (grant_oh),
      .grant_bin (grant_bin)
   );

   // The slot may be refilled on the same edge that the host consumes it.
   assign xfer        = out_valid & ~bus.txe_n_i;
   assign slot_free   = ~out_valid | xfer;
   assign any_req     = |grant_oh;
   assign start       = (state == IDLE) & any_req & slot_free;
   assign accept      = (state == PAYLOAD) & bus.req_valid_i[grant_q] & slot_free;
   assign last_accept = accept & (byte_cnt == CW'(BURST_LEN - 1));
   assign next_ptr    = (grant_bin == GW'(NCH - 1)) ? '0 : grant_bin + GW'(1);
   assign hdr_ch      = CH_W'(grant_bin);

   always_comb begin
      req_ready = '0;
      if (state == PAYLOAD) req_ready[grant_q] = bus.req_valid_i[grant_q] & slot_free;
   end

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clkout_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         data_q    <= '0;
         rr_ptr    <= '0;
         grant_q   <= '0;
         byte_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  out_valid <= 1'b1;
                  data_q    <= {HDR_MAGIC, hdr_ch};
                  rr_ptr    <= next_ptr;
                  grant_q   <= grant_bin;
                  byte_cnt  <= '0;
                  state     <= PAYLOAD;
               end else if (xfer) begin
                  out_valid <= 1'b0;
               end
            end
            PAYLOAD: begin
               if (accept) begin
                  out_valid <= 1'b1;
                  data_q    <= req_byte[grant_q];
                  byte_cnt  <= byte_cnt + CW'(1);
                  if (last_accept) state <= IDLE;
               end else if (xfer) begin
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef FT_SIWU_EN
   logic pkt_done;
   logic siwu_n_q;

   // A fresh request in the quiet cycle wins; the flush stays pending for a later gap.
   always_ff @(posedge clkout_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pkt_done <= 1'b0;
         siwu_n_q <= 1'b1;
      end else begin
         siwu_n_q <= 1'b1;
         if (last_accept) begin
            pkt_done <= 1'b1;
         end else if ((state == IDLE) && !out_valid && !any_req && pkt_done) begin
            pkt_done <= 1'b0;
            siwu_n_q <= 1'b0;
         end
      end
   end

   assign bus.siwu_n_o = siwu_n_q;
`else
   assign bus.siwu_n_o = 1'b1;
`endif

   assign bus.req_ready_o = req_ready;
   assign bus.wr_n_o      = ~xfer;
   assign bus.data_o      = data_q;
   assign bus.busy_o      = (state == PAYLOAD) | out_valid;

endmodule

// File: doc/ft2232h_tx_arbiter.md
Name: ft2232h_tx_arbiter

Overview:
- Round-robin TX scheduler that shares the FT2232H synchronous-FIFO write port (CLKOUT domain, 60 MHz) between NCH byte-stream requesters (ADC/status channels).
- Each grant emits one framed packet: header byte {HDR_MAGIC, ch}, then exactly BURST_LEN payload bytes from the granted channel.
- Sits between channel packetizers and the FT2232H pins (data, WR#, TXE#, SIWU#).

Parameters:
- NCH, 4, number of requesters (1..16).
- BURST_LEN, 16, payload bytes per packet (1..256).
- CH_W, 4, width of the channel field in the header byte (fixed at 4).

Ports:
- clkout_i  input  1  FT2232H CLKOUT; sole clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- req_valid_i  input  NCH  per-channel byte valid.
- req_data_i  input  NCH*8  per-channel byte, channel k at [8k+7:8k].
- req_ready_o  output  NCH  per-channel byte accepted this cycle.
- txe_n_i  input  1  FT2232H TXE#; low = FIFO can accept.
- wr_n_o  output  1  FT2232H WR#, active low.
- data_o  output  8  FT2232H data bus.
- siwu_n_o  output  1  FT2232H SIWU#, active low.
- busy_o  output  1  high while in PAYLOAD or output slot occupied.

Behaviour:
- Reset (async, immediate): state=IDLE, out_valid=0, data_o=8'h00, wr_n_o=1, siwu_n_o=1, req_ready_o=0, rr_ptr=0, byte_cnt=0.
- Output slot: a single register (out_valid, data_o). wr_n_o = ~(out_valid & ~txe_n_i), combinational. xfer = out_valid & ~txe_n_i at the rising edge; the byte is consumed on that edge.
- slot_free = ~out_valid | xfer. The slot loads only when slot_free. Back-to-back bytes sustain 1 byte/clk while TXE# is low.
- TXE# high: data_o and out_valid hold and wr_n_o=1. No byte is lost or duplicated. Resumes on the first cycle TXE# is low.
- IDLE:
  - If any req_valid_i and slot_free: grant = first requester with valid, searching from rr_ptr upward with wrap.
  - Load header {4'hA, grant[3:0]} into the slot, set rr_ptr = grant+1 mod NCH, set byte_cnt=0, go to PAYLOAD.
  - The header is loaded even if the requester drops valid afterwards.
  - No request: stay in IDLE.
- PAYLOAD:
  - req_ready_o[grant] = req_valid_i[grant] & slot_free; all other ready bits are 0.
  - On accept: slot <= req byte, byte_cnt++.
  - When an accept makes byte_cnt reach BURST_LEN: go to IDLE.
  - Requester valid low: wait indefinitely; no timeout; grant is held.
- Arbitration costs exactly 1 IDLE cycle between packets. The header of packet n+1 is loaded in the IDLE cycle following the last payload accept of packet n.
- A requester never sees ready outside its own grant. A valid asserted mid-burst by another channel waits.
- byte_cnt width: clog2(BURST_LEN+1). Header uses grant[3:0]; with NCH<16 the upper bits are 0.
- busy_o = (state==PAYLOAD) | out_valid.

Optional Feature:
- FT_SIWU_EN defined:
  - A flag is set at the end of each packet.
  - In IDLE with out_valid=0, no req_valid_i and the flag set: siwu_n_o is driven low for exactly 1 cycle and the flag is cleared.
  - A new request in the same cycle takes priority: no pulse, flag kept.
- Not defined: siwu_n_o is constantly 1 and no flag logic is synthesized.

Decomposition:
- Package ft2232h_pkg: HDR_MAGIC=4'hA, state enum {IDLE, PAYLOAD}, FT_BYTE_W=8.
- Sub-module rr_arbiter (NCH-wide request vector plus pointer in, one-hot and binary grant out; combinational), instantiated once.

Test Plan:
- Single channel 2, BURST_LEN=4, bytes 11,22,33,44, TXE# low throughout -> data_o stream A2,11,22,33,44 on 5 consecutive xfers; then 1 idle cycle before any next header.
- All 4 channels continuously valid -> headers A0,A1,A2,A3,A0 in order; each followed by exactly 4 payload bytes from that channel.
- TXE# high for 3 cycles while 0x22 is held in the slot -> wr_n_o=1 for those cycles, data_o=22 stable; 22 is transferred once when TXE# falls; host stream unchanged.
- Channel 1 valid drops after 2 payload bytes for 5 cycles -> no other header appears; packet completes with 4 bytes once valid returns.
- rst_n_i asserted mid-payload -> same-time wr_n_o=1 and data_o=00; after release the first byte is a fresh header at rr_ptr=0.
- FT_SIWU_EN, one packet then no requests -> single-cycle siwu_n_o low after the last payload xfer. Request arriving in that IDLE cycle -> no pulse; header emitted instead.
